// File: rtl/memory_access_mc.sv
// Memory-access stage: decodes the M-stage instruction, runs one bus transaction and returns valM/stat.
// Define MEM_TIMEOUT_EN to add a wait counter that aborts an unacknowledged access after TIMEOUT cycles.
module memory_access_mc #(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int MEM_BYTES = 8192,
    parameter int TIMEOUT   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              M_valid_i,
    input  logic [3:0]        M_icode_i,
    input  logic [ADDR_W-1:0] M_valE_i,
    input  logic [DATA_W-1:0] M_valA_i,
    input  logic [2:0]        M_stat_i,
    output logic              m_valid_o,
    output logic [DATA_W-1:0] m_valM_o,
    output logic [2:0]        m_stat_o,
    output logic              m_stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_err_i
);
    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SADR = 3'd3;
    localparam int         AW1  = ADDR_W + 1;
    localparam logic [AW1-1:0] LIMIT = AW1'(MEM_BYTES);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e            state_q, state_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] valm_q, valm_d;
    logic [2:0]        stat_q, stat_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rd_q, rd_d;

    logic              is_write, is_read, use_vala, out_of_range, accept;
    logic [ADDR_W-1:0] vala_addr, acc_addr;

    // popq/ret address the stack through valA, which may differ in width from the address bus
    generate
        if (DATA_W >= ADDR_W) begin : g_vala_trunc
            assign vala_addr = M_valA_i[ADDR_W-1:0];
        end else begin : g_vala_ext
            assign vala_addr = {{(ADDR_W-DATA_W){1'b0}}, M_valA_i};
        end
    endgenerate

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    always_comb begin
        is_write     = (M_icode_i == 4'h4) || (M_icode_i == 4'hA) || (M_icode_i == 4'h8);
        is_read      = (M_icode_i == 4'h5) || (M_icode_i == 4'hB) || (M_icode_i == 4'h9);
        use_vala     = (M_icode_i == 4'hB) || (M_icode_i == 4'h9);
        acc_addr     = use_vala ? vala_addr : M_valE_i;
        out_of_range = ({1'b0, acc_addr} + AW1'(8)) > LIMIT;
        accept       = (state_q == IDLE) && M_valid_i && (is_write || is_read)
                       && (M_stat_i == SAOK) && !out_of_range;
    end

    always_comb begin
        state_d = state_q;
        valid_d = 1'b0;
        valm_d  = valm_q;
        stat_d  = stat_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                    req_d   = 1'b1;
                    we_d    = is_write;
                    addr_d  = acc_addr;
                    wdata_d = M_valA_i;
                    rd_d    = is_read;
`ifdef MEM_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end else if (M_valid_i) begin
                    // a healthy instruction that wanted memory but was refused must be out of range
                    valid_d = 1'b1;
                    valm_d  = '0;
                    stat_d  = ((M_stat_i == SAOK) && (is_write || is_read)) ? SADR : M_stat_i;
                end
            end
            BUSY: begin
                if (mem_ack_i) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    valm_d  = rd_q ? mem_rdata_i : '0;
                    stat_d  = mem_err_i ? SADR : SAOK;
`ifdef MEM_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    valm_d  = '0;
                    stat_d  = SADR;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            valm_q  <= '0;
            stat_q  <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            valm_q  <= valm_d;
            stat_q  <= stat_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign m_valid_o   = valid_q;
    assign m_valM_o    = valm_q;
    assign m_stat_o    = stat_q;
    assign m_stall_o   = (state_q == BUSY) || accept;
    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
endmodule

// File: tb/tb_memory_access_mc.sv
// Scoreboard bench for memory_access_mc: expected valM/stat pairs are queued when an
// instruction is driven and compared whenever m_valid_o is seen on a falling edge.
module tb_memory_access_mc;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        M_valid_i;
    logic [3:0]  M_icode_i;
    logic [63:0] M_valE_i;
    logic [63:0] M_valA_i;
    logic [2:0]  M_stat_i;
    logic        m_valid_o;
    logic [63:0] m_valM_o;
    logic [2:0]  m_stat_o;
    logic        m_stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [63:0] mem_addr_o;
    logic [63:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [63:0] mem_rdata_i;
    logic        mem_err_i;

    typedef struct {
        logic [63:0] valm;
        logic [2:0]  stat;
    } result_t;

    result_t expQ[$];
    int      checks = 0;
    int      errors = 0;

    memory_access_mc dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .M_valid_i   (M_valid_i),
        .M_icode_i   (M_icode_i),
        .M_valE_i    (M_valE_i),
        .M_valA_i    (M_valA_i),
        .M_stat_i    (M_stat_i),
        .m_valid_o   (m_valid_o),
        .m_valM_o    (m_valM_o),
        .m_stat_o    (m_stat_o),
        .m_stall_o   (m_stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .mem_err_i   (mem_err_i)
    );

    always #5 clk_i = ~clk_i;

    // Hard stop in case something stalls the stimulus sequence.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired got=running exp=finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge and score any result the DUT presents there.
    task automatic tick();
        result_t e;
        @(negedge clk_i);
        if (m_valid_o === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_valid", 64'(m_valid_o), 64'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("sb_valm", m_valM_o, e.valm);
                checkOutput("sb_stat", 64'(m_stat_o), 64'(e.stat));
            end
        end
    endtask

    task automatic applyStimulus(input logic [3:0] icode, input logic [63:0] vale,
                                 input logic [63:0] vala, input logic [2:0] stat);
        M_valid_i = 1'b1;
        M_icode_i = icode;
        M_valE_i  = vale;
        M_valA_i  = vala;
        M_stat_i  = stat;
    endtask

    task automatic pushExpect(input logic [63:0] valm, input logic [2:0] stat);
        result_t e;
        e.valm = valm;
        e.stat = stat;
        expQ.push_back(e);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_valid"}, 64'(m_valid_o), 64'd0);
        checkOutput({tag, "_valm"},  m_valM_o, 64'd0);
        checkOutput({tag, "_stat"},  64'(m_stat_o), 64'd0);
        checkOutput({tag, "_stall"}, 64'(m_stall_o), 64'd0);
        checkOutput({tag, "_req"},   64'(mem_req_o), 64'd0);
        checkOutput({tag, "_we"},    64'(mem_we_o), 64'd0);
        checkOutput({tag, "_addr"},  mem_addr_o, 64'd0);
        checkOutput({tag, "_wdata"}, mem_wdata_o, 64'd0);
    endtask

    // Instruction that never reaches the bus: one-cycle result, no stall.
    task automatic runNoBus(input logic [3:0] icode, input logic [63:0] vale, input logic [63:0] vala,
                            input logic [2:0] stat, input logic [2:0] expStat);
        pushExpect(64'd0, expStat);
        applyStimulus(icode, vale, vala, stat);
        #1;
        checkOutput("nobus_stall", 64'(m_stall_o), 64'd0);
        tick();
        M_valid_i = 1'b0;
        checkOutput("nobus_req", 64'(mem_req_o), 64'd0);
        checkOutput("nobus_drained", 64'(expQ.size()), 64'd0);
    endtask

    // Full bus transaction; ack is raised in BUSY cycle ackDelay.
    task automatic runAccess(input logic [3:0] icode, input logic [63:0] vale, input logic [63:0] vala,
                             input int ackDelay, input logic [63:0] rdata, input logic err,
                             input logic expWe, input logic [63:0] expAddr, input logic [63:0] expWdata,
                             input logic [63:0] expValm, input logic [2:0] expStat, input int expStalls);
        int stalls = 0;
        pushExpect(expValm, expStat);
        applyStimulus(icode, vale, vala, 3'd1);
        #1;
        if (m_stall_o) stalls++;
        tick();
        M_valid_i = 1'b0;
        checkOutput("bus_req",   64'(mem_req_o), 64'd1);
        checkOutput("bus_we",    64'(mem_we_o), 64'(expWe));
        checkOutput("bus_addr",  mem_addr_o, expAddr);
        checkOutput("bus_wdata", mem_wdata_o, expWdata);
        for (int i = 1; i <= ackDelay; i++) begin
            if (m_stall_o) stalls++;
            if (i == ackDelay) begin
                checkOutput("bus_req_held",  64'(mem_req_o), 64'd1);
                checkOutput("bus_addr_held", mem_addr_o, expAddr);
                mem_ack_i   = 1'b1;
                mem_rdata_i = rdata;
                mem_err_i   = err;
            end
            tick();
        end
        mem_ack_i = 1'b0;
        mem_err_i = 1'b0;
        if (m_stall_o) stalls++;
        checkOutput("done_req", 64'(mem_req_o), 64'd0);
        checkOutput("done_drained", 64'(expQ.size()), 64'd0);
        tick();
        checkOutput("stall_cycles", 64'(stalls), 64'(expStalls));
        checkOutput("valid_one_cycle", 64'(m_valid_o), 64'd0);
    endtask

    initial begin
        int n;
        rst_i       = 1'b1;
        M_valid_i   = 1'b0;
        M_icode_i   = 4'h0;
        M_valE_i    = '0;
        M_valA_i    = '0;
        M_stat_i    = 3'd0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        mem_err_i   = 1'b0;
        tick();
        tick();
        checkAllZero("reset");
        rst_i = 1'b0;
        tick();

        runNoBus(4'h6, 64'h0, 64'h0, 3'd1, 3'd1);
        runAccess(4'hB, 64'h999, 64'h80, 1, 64'h1234, 1'b0, 1'b0, 64'h80, 64'h80, 64'h1234, 3'd1, 2);
        runAccess(4'h5, 64'h100, 64'h7, 3, 64'hDEADBEEF, 1'b0, 1'b0, 64'h100, 64'h7, 64'hDEADBEEF, 3'd1, 4);
        runAccess(4'hA, 64'h40, 64'h55, 2, 64'hFFFF, 1'b1, 1'b1, 64'h40, 64'h55, 64'h0, 3'd3, 3);
        runAccess(4'h8, 64'h200, 64'h77, 1, 64'hABCD, 1'b0, 1'b1, 64'h200, 64'h77, 64'h0, 3'd1, 2);
        runAccess(4'h9, 64'h5, 64'h1000, 1, 64'h42, 1'b0, 1'b0, 64'h1000, 64'h1000, 64'h42, 3'd1, 2);
        runAccess(4'h4, 64'h1FF8, 64'h99, 1, 64'h0, 1'b0, 1'b1, 64'h1FF8, 64'h99, 64'h0, 3'd1, 2);

        runNoBus(4'h4, 64'h1FF9, 64'h0, 3'd1, 3'd3);
        runNoBus(4'hB, 64'h10, 64'h3000, 3'd1, 3'd3);
        runNoBus(4'h5, 64'h100, 64'h0, 3'd2, 3'd2);
        runNoBus(4'h5, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 3'd1, 3'd3);

        // Idle with a stray ack: nothing may fire and the last result must hold.
        mem_ack_i   = 1'b1;
        mem_rdata_i = 64'h5A5A;
        tick();
        tick();
        mem_ack_i = 1'b0;
        tick();
        checkOutput("hold_stat", 64'(m_stat_o), 64'd3);
        checkOutput("hold_valm", m_valM_o, 64'd0);
        checkOutput("stray_ack_req", 64'(mem_req_o), 64'd0);

        // Reset in the second BUSY cycle, ack arriving just after it.
        applyStimulus(4'h5, 64'h100, 64'h0, 3'd1);
        tick();
        M_valid_i = 1'b0;
        tick();
        rst_i = 1'b1;
        tick();
        rst_i       = 1'b0;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 64'hBAD;
        checkAllZero("rst_busy");
        tick();
        mem_ack_i = 1'b0;
        checkAllZero("rst_after_ack");
        tick();
        checkOutput("rst_no_valid", 64'(m_valid_o), 64'd0);
        runNoBus(4'h6, 64'h0, 64'h0, 3'd1, 3'd1);

        // Read that is never acknowledged.
`ifdef MEM_TIMEOUT_EN
        pushExpect(64'h0, 3'd3);
`else
        pushExpect(64'hCAFE, 3'd1);
`endif
        applyStimulus(4'h5, 64'h300, 64'h0, 3'd1);
        tick();
        M_valid_i = 1'b0;
        n = 0;
        while (mem_req_o && n < 40) begin
            n++;
            tick();
        end
`ifdef MEM_TIMEOUT_EN
        checkOutput("timeout_cycles", 64'(n), 64'd16);
`else
        checkOutput("no_timeout_req_held", 64'(n), 64'd40);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 64'hCAFE;
        tick();
        mem_ack_i = 1'b0;
        tick();
`endif
        tick();
        checkOutput("final_drained", 64'(expQ.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/memory_access_mc.md
MEMORY_ACCESS_MC -- requirements
Module: memory_access_mc

Interface
REQ-001 SHALL have parameter ADDR_W, default 64: width of the data address.
REQ-002 SHALL have parameter DATA_W, default 64: width of the data word.
REQ-003 SHALL have parameter MEM_BYTES, default 8192: size of the legal data address space in bytes.
REQ-004 SHALL have parameter TIMEOUT, default 16: maximum number of wait cycles for an acknowledge.
REQ-005 SHALL have port clk_i, input, 1: the only clock; all state SHALL update on the rising edge.
REQ-006 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have these M-stage inputs: M_valid_i (1), M_icode_i (4), M_valE_i (ADDR_W), M_valA_i (DATA_W), M_stat_i (3).
REQ-008 SHALL have these m-stage outputs: m_valid_o (1), m_valM_o (DATA_W), m_stat_o (3), m_stall_o (1, held high while a bus access is outstanding).
REQ-009 SHALL have these bus outputs: mem_req_o (1), mem_we_o (1), mem_addr_o (ADDR_W), mem_wdata_o (DATA_W).
REQ-010 SHALL have these bus inputs: mem_ack_i (1), mem_rdata_i (DATA_W), mem_err_i (1).

Function
REQ-011 SHALL decode the access type as follows: rmmovq (4), pushq (A) and call (8) write to valE; mrmovq (5) reads from valE; popq (B) and ret (9) read from valA; every other icode makes no access.
REQ-012 SHALL use a three-state FSM with states IDLE, BUSY and DONE.
REQ-013 In IDLE with no accepted access, SHALL register valM=0 and stat=M_stat_i, and SHALL pulse m_valid_o for one cycle if M_valid_i is high, giving a latency of 1.
REQ-014 SHALL skip the bus and return no access when M_stat_i is not SAOK (1).
REQ-015 SHALL treat an access as out of range when addr+8 exceeds MEM_BYTES, computed at ADDR_W+1 bits so no wrap is possible.
REQ-016 For an out-of-range access, SHALL skip the bus, output stat SADR (3) after 1 cycle, and keep m_stall_o low.
REQ-017 For a legal access in IDLE, SHALL move to BUSY and raise mem_req_o in the same cycle.
REQ-018 mem_addr_o, mem_we_o and mem_wdata_o SHALL be registered copies of the access fields and SHALL stay stable while mem_req_o is high.
REQ-019 m_stall_o SHALL be high combinationally in the cycle of acceptance and for every cycle spent in BUSY.
REQ-020 M-stage inputs SHALL be ignored while BUSY; upstream holds them stable under stall.
REQ-021 In BUSY, when mem_ack_i=1, SHALL drop mem_req_o on the next edge, capture mem_rdata_i for reads (valM=0 for writes), set stat=SADR if mem_err_i=1 and SAOK otherwise, and move to DONE.
REQ-022 In DONE, SHALL hold m_valid_o=1 for exactly one cycle and then return to IDLE; a new access SHALL NOT be accepted in DONE.
REQ-023 mem_ack_i while not in BUSY SHALL be ignored.
REQ-024 m_valM_o and m_stat_o SHALL hold their value until the next m_valid_o pulse.

Reset
REQ-025 When rst_i=1 at a clock edge, SHALL go to IDLE and clear every output to 0: m_valid_o, m_valM_o, m_stat_o, m_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o.
REQ-026 Reset during BUSY SHALL abandon the access with no m_valid_o pulse, and a later ack SHALL be ignored.
REQ-027 Reset SHALL take priority over every other event in the same cycle.

Configuration
REQ-028 With macro MEM_TIMEOUT_EN defined, a wait counter SHALL clear on entry to BUSY and increment each BUSY cycle without ack.
REQ-029 With MEM_TIMEOUT_EN defined, when the count reaches TIMEOUT, SHALL drop mem_req_o, set stat=SADR and valM=0, and move to DONE.
REQ-030 With MEM_TIMEOUT_EN undefined, no counter SHALL exist and BUSY SHALL wait indefinitely for ack.

Verification
REQ-031 mrmovq, valE=0x100, stat=1, ack after 3 cycles with rdata=0xDEADBEEF -> m_stall_o high for 4 cycles, then m_valid_o pulse with valM=0xDEADBEEF and stat=1.
REQ-032 rmmovq, valE=0x1FF9, MEM_BYTES=8192 -> no mem_req_o, m_stat_o=3 after 1 cycle, m_stall_o never high.
REQ-033 pushq, valE=0x40, valA=0x55, ack with err=1 -> bus shows we=1, addr=0x40, wdata=0x55, then m_stat_o=3.
REQ-034 opq (icode 6) followed by popq, valA=0x80, with a 1-cycle ack -> first result after 1 cycle; second read goes to addr 0x80 and m_valid_o pulses in DONE.
REQ-035 rst_i raised in the 2nd BUSY cycle, ack on the next cycle -> all outputs 0, no m_valid_o pulse, FSM in IDLE.
REQ-036 With MEM_TIMEOUT_EN and TIMEOUT=16, a read with no ack -> mem_req_o drops after 16 BUSY cycles, then m_stat_o=3 and valM=0; without the macro, mem_req_o stays high.
